// File: rtl/fib_pkg.sv
// Shared constants and types for the Fibonacci stream checker and its helpers.
package fib_pkg;

   localparam int FIB_W      = 16;
   localparam int FIB_SEED_A = 1;
   localparam int FIB_SEED_B = 1;

   typedef enum logic {
      CHECK = 1'b0,
      ERROR = 1'b1
   } fib_state_t;

endpackage

// File: rtl/fib_advance.sv
// Combinational step of the Fibonacci pair by one number (single) or two (double).
module fib_advance #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         dbl,
   output logic [W-1:0] next_a,
   output logic [W-1:0] next_b
);

   logic [W-1:0] sum_ab;
   logic [W-1:0] sum_abb;

   // Truncating adds: wrap-around matches the generator's own truncation.
   assign sum_ab  = a + b;
   assign sum_abb = sum_ab + b;

   always_comb begin
      next_a = b;
      next_b = sum_ab;
      if (dbl) begin
         next_a = sum_ab;
         next_b = sum_abb;
      end
   end

endmodule

// File: rtl/fibonacci_checker.sv
// Self-checking sink for single- and double-rate Fibonacci streams with a
// sticky first-error record and a saturating match counter.
module fibonacci_checker
   import fib_pkg::*;
#(
   parameter int W     = FIB_W,
   parameter int IDX_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             in_double,
   input  logic [W-1:0]     in_num,
   input  logic [W-1:0]     in_num2,
   output logic             in_ready,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic             err,
   output logic [IDX_W-1:0] err_index,
   output logic [W-1:0]     err_expected,
   output logic [W-1:0]     err_got,
   output logic [IDX_W-1:0] match_count
);

   fib_state_t       state, state_nxt;
   logic             ready_q;
   logic [W-1:0]     exp_a, exp_b;
   logic [W-1:0]     nxt_a, nxt_b;
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic             lane0_ok, lane1_ok, beat_ok;

   function automatic logic [IDX_W-1:0] sat_add(input logic [IDX_W-1:0] cnt,
                                                input logic             two);
      logic [IDX_W:0] sum;
      sum = {1'b0, cnt} + (two ? (IDX_W+1)'(2) : (IDX_W+1)'(1));
      return sum[IDX_W] ? {IDX_W{1'b1}} : sum[IDX_W-1:0];
   endfunction

   fib_advance #(.W(W)) u_adv (
      .a      (exp_a),
      .b      (exp_b),
      .dbl    (in_double),
      .next_a (nxt_a),
      .next_b (nxt_b)
   );

   assign accept   = in_valid & in_ready;
   assign lane0_ok = (in_num == exp_a);
   assign lane1_ok = ~in_double | (in_num2 == exp_b);
   assign beat_ok  = lane0_ok & lane1_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= CHECK;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr)
         state_nxt = CHECK;
      else if (state == CHECK && accept && !beat_ok)
         state_nxt = ERROR;
   end

   // Readiness is the same in both states; clr always blocks acceptance.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         CHECK:   in_ready = ready_q & ~clr;
         ERROR:   in_ready = ready_q & ~clr;
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q      <= 1'b0;
         exp_a        <= W'(FIB_SEED_A);
         exp_b        <= W'(FIB_SEED_B);
         idx          <= '0;
         chk_valid    <= 1'b0;
         chk_pass     <= 1'b0;
         err          <= 1'b0;
         err_index    <= '0;
         err_expected <= '0;
         err_got      <= '0;
         match_count  <= '0;
      end else begin
         ready_q   <= 1'b1;
         chk_valid <= accept;
         chk_pass  <= 1'b0;
         if (clr) begin
            exp_a        <= W'(FIB_SEED_A);
            exp_b        <= W'(FIB_SEED_B);
            idx          <= '0;
            err          <= 1'b0;
            err_index    <= '0;
            err_expected <= '0;
            err_got      <= '0;
            match_count  <= '0;
         end else if (accept && state == CHECK) begin
            if (beat_ok) begin
               chk_pass    <= 1'b1;
               exp_a       <= nxt_a;
               exp_b       <= nxt_b;
               idx         <= idx + (in_double ? IDX_W'(2) : IDX_W'(1));
               match_count <= sat_add(match_count, in_double);
            end else begin
               // Lane 0 takes priority when both lanes are wrong.
               err <= 1'b1;
               if (!lane0_ok) begin
                  err_index    <= idx;
                  err_expected <= exp_a;
                  err_got      <= in_num;
               end else begin
                  err_index    <= idx + IDX_W'(1);
                  err_expected <= exp_b;
                  err_got      <= in_num2;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker: stimulus pushes expected pass flags,
// a negedge monitor pops them on every chk_valid pulse.
module tb_fibonacci_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        in_valid;
   logic        in_double;
   logic [15:0] in_num;
   logic [15:0] in_num2;
   logic        in_ready;
   logic        chk_valid;
   logic        chk_pass;
   logic        err;
   logic [15:0] err_index;
   logic [15:0] err_expected;
   logic [15:0] err_got;
   logic [15:0] match_count;

   int checks = 0;
   int errors = 0;
   bit exp_q[$];

   fibonacci_checker #(.W(16), .IDX_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .in_valid     (in_valid),
      .in_double    (in_double),
      .in_num       (in_num),
      .in_num2      (in_num2),
      .in_ready     (in_ready),
      .chk_valid    (chk_valid),
      .chk_pass     (chk_pass),
      .err          (err),
      .err_index    (err_index),
      .err_expected (err_expected),
      .err_got      (err_got),
      .match_count  (match_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every pulse must have a queued expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && chk_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_chk_valid: got pulse expected none");
         end else begin
            bit e;
            e = exp_q.pop_front();
            if (chk_pass !== e) begin
               errors++;
               $display("FAIL chk_pass: got %0b expected %0b", chk_pass, e);
            end
         end
      end
   end

   task automatic send(input bit dbl, input logic [15:0] a, input logic [15:0] b, input bit pass);
      int n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got in_ready=%0b expected 1", in_ready);
         return;
      end
      in_valid  = 1'b1;
      in_double = dbl;
      in_num    = a;
      in_num2   = b;
      exp_q.push_back(pass);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_double = 1'b0;
   endtask

   task automatic status(input string name, input logic [15:0] mc, input logic e);
      @(negedge clk);
      chk({name, "_match_count"}, match_count, mc);
      chk({name, "_err"}, err, e);
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      logic [15:0] a, b, t;
      rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_double = 1'b0;
      in_num = '0; in_num2 = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_chk_valid", chk_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_match_count", match_count, 0);
      chk("rst_err_index", err_index, 0);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rel_in_ready_before_edge", in_ready, 0);
      @(posedge clk);
      #1 chk("rel_in_ready_after_edge", in_ready, 1);

      // 1: single rate
      send(0, 1, 0, 1); send(0, 1, 0, 1); send(0, 2, 0, 1);
      send(0, 3, 0, 1); send(0, 5, 0, 1); send(0, 8, 0, 1);
      status("single", 6, 0);

      // 2: double rate
      do_clr();
      send(1, 1, 1, 1); send(1, 2, 3, 1); send(1, 5, 8, 1); send(1, 13, 21, 1);
      status("double", 8, 0);

      // 3: mixed rate
      do_clr();
      send(0, 1, 0, 1); send(1, 1, 2, 1); send(0, 3, 0, 1); send(1, 5, 8, 1);
      status("mixed", 6, 0);

      // 4: error path, lane 0
      do_clr();
      send(0, 1, 0, 1); send(0, 1, 0, 1); send(0, 2, 0, 1); send(0, 4, 0, 0);
      status("err1", 3, 1);
      chk("err1_index", err_index, 3);
      chk("err1_expected", err_expected, 3);
      chk("err1_got", err_got, 4);
      send(0, 5, 0, 0); send(0, 8, 0, 0);
      status("err1_drain", 3, 1);
      chk("err1_index_frozen", err_index, 3);

      // 4b: lane-1-only mismatch on first beat
      do_clr();
      send(1, 1, 9, 0);
      status("err2", 0, 1);
      chk("err2_index", err_index, 1);
      chk("err2_expected", err_expected, 1);
      chk("err2_got", err_got, 9);

      // 5: wrap-around at index 24
      do_clr();
      a = 16'd1; b = 16'd1;
      for (int i = 0; i < 23; i++) begin
         send(0, a, 0, 1);
         t = a + b; a = b; b = t;
      end
      send(0, 16'd46368, 0, 1);
      send(0, 16'd9489, 0, 1);
      status("wrap", 25, 0);

      // 6a: clr with a simultaneous beat (status carries an error first)
      send(0, 7, 0, 0);
      status("pre_clr", 25, 1);
      @(negedge clk);
      clr = 1'b1; in_valid = 1'b1; in_num = 16'd1;
      #1 chk("clr_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      clr = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("clr_chk_valid", chk_valid, 0);
      chk("clr_err", err, 0);
      chk("clr_match_count", match_count, 0);
      chk("clr_err_index", err_index, 0);
      send(0, 1, 0, 1); send(0, 1, 0, 1);
      status("after_clr", 2, 0);

      // 6b: async reset mid-stream, beat presented during reset is dropped
      send(0, 2, 0, 1); send(0, 5, 0, 0);
      status("pre_rst", 3, 1);
      @(negedge clk);
      #2;
      rst = 1'b0;
      in_valid = 1'b1; in_num = 16'd3;
      #1;
      chk("arst_in_ready", in_ready, 0);
      chk("arst_err", err, 0);
      chk("arst_match_count", match_count, 0);
      chk("arst_err_got", err_got, 0);
      @(posedge clk);
      @(negedge clk);
      chk("arst_chk_valid", chk_valid, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1 chk("arst_rel_in_ready", in_ready, 0);
      @(posedge clk);
      #1 chk("arst_rel_in_ready_edge", in_ready, 1);
      send(0, 1, 0, 1); send(0, 1, 0, 1); send(0, 2, 0, 1);
      status("after_rst", 3, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
